// File: rtl/modulo_contador_rolhas_duzias_pkg.sv
// Shared constants for the sealing-line stages: FSM encoding and parameter defaults.
// Pure declarations, no logic, no latency.
// No flow control; imported by the counter and by the edge detector.
package modulo_contador_rolhas_duzias_pkg;

  // Box-handling states: counting bottles, exchanging the box, out of corks
  typedef enum logic [1:0] {
    CONTA = 2'd0,
    TROCA = 2'd1,
    VAZIO = 2'd2
  } estado_t;

  localparam int STOCK_MAX_DEF    = 99;
  localparam int RELOAD_QTY_DEF   = 15;
  localparam int LOW_THRESH_DEF   = 5;
  localparam int TROCA_CYCLES_DEF = 4;

  localparam int GARRAFAS_ULTIMA  = 11;  // last bottle index of a dozen box
  localparam int DUZIAS_MAX       = 99;  // box counter saturates here

  // Clamp an 8-bit intermediate to a ceiling before it reaches a register
  function automatic logic [7:0] sat8(input logic [7:0] v, input logic [7:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/modulo_detector_borda.sv
// Rising-edge detector for the seal command level.
// Pulse is combinational from d against a one-cycle history register.
// No backpressure; history updates every cycle so edges are never deferred.
module modulo_detector_borda
  import modulo_contador_rolhas_duzias_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulso
);

  logic prev;

  // Previous-cycle sample of d, cleared on reset
  always_ff @(posedge clk) begin
    if (!rst) prev <= 1'b0;
    else      prev <= d;
  end

  assign pulso = d & ~prev;

endmodule

// File: rtl/modulo_contador_rolhas_duzias.sv
// Cork stock / bottle / dozen-box counter with box-exchange FSM.
// Counts update one cycle after a seal edge; status outputs decode registered state.
// enable low freezes everything; eb tells the upstream FSM to hold the conveyor.
module modulo_contador_rolhas_duzias
  import modulo_contador_rolhas_duzias_pkg::*;
#(
  parameter int STOCK_MAX    = STOCK_MAX_DEF,
  parameter int RELOAD_QTY   = RELOAD_QTY_DEF,
  parameter int LOW_THRESH   = LOW_THRESH_DEF,
  parameter int TROCA_CYCLES = TROCA_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       ve,
  input  logic       add_rolha,
  output logic       ro,
  output logic       eb,
  output logic       troca_caixa,
  output logic       estoque_baixo,
  output logic       erro,
  output logic [3:0] garrafas,
  output logic [6:0] rolhas,
  output logic [6:0] duzias
);

  estado_t    estado;
  logic [7:0] troca_cnt;
  logic       pulso;
  logic       aceita;
  logic       rejeita;
  logic       fecha_caixa;
  logic [7:0] rolhas_soma;
  logic [7:0] rolhas_nx;

  modulo_detector_borda u_borda (
    .clk   (clk),
    .rst   (rst),
    .d     (ve),
    .pulso (pulso)
  );

  // Seal acceptance and next cork stock; seals during an exchange are dropped silently
  always_comb begin
    aceita      = 1'b0;
    rejeita     = 1'b0;
    fecha_caixa = 1'b0;
    rolhas_soma = 8'd0;
    rolhas_nx   = 8'd0;
    if (enable && pulso && estado != TROCA) begin
      aceita  = (rolhas != 7'd0);
      rejeita = (rolhas == 7'd0);
    end
    fecha_caixa = aceita && (garrafas == 4'(GARRAFAS_ULTIMA));
    rolhas_soma = {1'b0, rolhas} - (aceita ? 8'd1 : 8'd0)
                + (add_rolha ? 8'(RELOAD_QTY) : 8'd0);
    rolhas_nx   = sat8(rolhas_soma, 8'(STOCK_MAX));
  end

  // Counters, sticky error and box-exchange FSM
  always_ff @(posedge clk) begin
    if (!rst) begin
      garrafas  <= 4'd0;
      duzias    <= 7'd0;
      rolhas    <= 7'(STOCK_MAX);
      erro      <= 1'b0;
      estado    <= CONTA;
      troca_cnt <= 8'd0;
    end else if (enable) begin
      rolhas <= rolhas_nx[6:0];
      if (aceita) begin
        garrafas <= fecha_caixa ? 4'd0 : garrafas + 4'd1;
        if (fecha_caixa && duzias != 7'(DUZIAS_MAX)) duzias <= duzias + 7'd1;
      end
      if (rejeita) erro <= 1'b1;
      case (estado)
        TROCA: begin
          if (troca_cnt == 8'(TROCA_CYCLES - 1)) begin
            troca_cnt <= 8'd0;
            estado    <= (rolhas_nx == 8'd0) ? VAZIO : CONTA;
          end else begin
            troca_cnt <= troca_cnt + 8'd1;
          end
        end
        default: begin
          // VAZIO waits for a registered non-zero stock before resuming
          if (estado == VAZIO && rolhas == 7'd0) estado <= VAZIO;
          else if (fecha_caixa) begin
            estado    <= TROCA;
            troca_cnt <= 8'd0;
          end
          else if (rolhas_nx == 8'd0) estado <= VAZIO;
          else                        estado <= CONTA;
        end
      endcase
    end
  end

  // Status decodes of registered state only
  always_comb begin
    ro            = (rolhas != 7'd0);
    eb            = (estado != CONTA);
    troca_caixa   = (estado == TROCA);
    estoque_baixo = ({1'b0, rolhas} <= 8'(LOW_THRESH));
  end

endmodule

// File: tb/tb_modulo_contador_rolhas_duzias.sv
module tb_modulo_contador_rolhas_duzias;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       ve;
  logic       add_rolha;
  logic       ro;
  logic       eb;
  logic       troca_caixa;
  logic       estoque_baixo;
  logic       erro;
  logic [3:0] garrafas;
  logic [6:0] rolhas;
  logic [6:0] duzias;

  int tests = 0;
  int fails = 0;

  modulo_contador_rolhas_duzias dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .ve            (ve),
    .add_rolha     (add_rolha),
    .ro            (ro),
    .eb            (eb),
    .troca_caixa   (troca_caixa),
    .estoque_baixo (estoque_baixo),
    .erro          (erro),
    .garrafas      (garrafas),
    .rolhas        (rolhas),
    .duzias        (duzias)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One isolated seal pulse, spaced so it never lands inside an exchange
  task automatic pulse_spaced();
    ve = 1'b1; step(1);
    ve = 1'b0; step(5);
  endtask

  initial begin
    rst = 1'b0; enable = 1'b1; ve = 1'b0; add_rolha = 1'b0;
    step(2);
    rst = 1'b1;

    // Reset state
    check("rst_garrafas", garrafas, 0);
    check("rst_duzias", duzias, 0);
    check("rst_rolhas", rolhas, 99);
    check("rst_erro", erro, 0);
    check("rst_ro", ro, 1);
    check("rst_eb", eb, 0);
    check("rst_troca", troca_caixa, 0);
    check("rst_baixo", estoque_baixo, 0);

    // First 11 seals: 1 high, 3 low
    for (int i = 1; i <= 11; i++) begin
      ve = 1'b1; step(1);
      check("seq_garrafas", garrafas, i);
      check("seq_rolhas", rolhas, 99 - i);
      ve = 1'b0; step(3);
    end
    check("seq_duzias_before", duzias, 0);

    // 12th seal closes the box
    ve = 1'b1; step(1);
    check("box_garrafas", garrafas, 0);
    check("box_duzias", duzias, 1);
    check("box_rolhas", rolhas, 87);
    check("troca_c1", troca_caixa, 1);
    check("eb_c1", eb, 1);
    ve = 1'b0; step(1);
    check("troca_c2", troca_caixa, 1);
    ve = 1'b1; step(1);          // edge during exchange, must be ignored
    check("troca_c3", troca_caixa, 1);
    check("eb_c3", eb, 1);
    ve = 1'b0; step(1);
    check("troca_c4", troca_caixa, 1);
    step(1);
    check("troca_end", troca_caixa, 0);
    check("eb_end", eb, 0);
    check("troca_ign_garrafas", garrafas, 0);
    check("troca_ign_rolhas", rolhas, 87);
    check("troca_ign_erro", erro, 0);

    // ve held high for 10 cycles counts once
    ve = 1'b1; step(10);
    ve = 1'b0; step(1);
    check("held_garrafas", garrafas, 1);
    check("held_rolhas", rolhas, 86);

    // Edge while disabled is lost, not deferred
    enable = 1'b0; ve = 1'b1; step(2);
    enable = 1'b1; step(3);
    ve = 1'b0; step(1);
    check("dis_garrafas", garrafas, 1);
    check("dis_rolhas", rolhas, 86);

    // Drain the remaining 86 corks (99 accepted seals in total)
    for (int i = 0; i < 86; i++) pulse_spaced();
    check("drain_rolhas", rolhas, 0);
    check("drain_ro", ro, 0);
    check("drain_eb", eb, 1);
    check("drain_baixo", estoque_baixo, 1);
    check("drain_troca", troca_caixa, 0);
    check("drain_duzias", duzias, 8);
    check("drain_garrafas", garrafas, 3);
    check("drain_erro", erro, 0);

    // Seal with no cork sets the sticky error and changes no counter
    pulse_spaced();
    check("empty_erro", erro, 1);
    check("empty_garrafas", garrafas, 3);
    check("empty_rolhas", rolhas, 0);

    // Restock from empty
    add_rolha = 1'b1; step(1);
    add_rolha = 1'b0;
    check("restock_rolhas", rolhas, 15);
    check("restock_ro", ro, 1);
    step(1);
    check("restock_eb", eb, 0);
    check("restock_erro_sticky", erro, 1);

    // Restock up to 90, then saturate at 99
    add_rolha = 1'b1; step(5);
    add_rolha = 1'b0;
    check("reload_90", rolhas, 90);
    add_rolha = 1'b1; step(1);
    add_rolha = 1'b0;
    check("reload_sat", rolhas, 99);

    // Drain to one cork
    for (int i = 0; i < 98; i++) pulse_spaced();
    check("one_rolhas", rolhas, 1);
    check("one_baixo", estoque_baixo, 1);
    check("one_ro", ro, 1);

    // Seal and restock in the same cycle: 1 - 1 + 15
    ve = 1'b1; add_rolha = 1'b1; step(1);
    ve = 1'b0; add_rolha = 1'b0;
    check("combo_rolhas", rolhas, 15);
    check("combo_garrafas", garrafas, 6);
    check("combo_duzias", duzias, 16);
    step(5);

    // Six more seals reach the exchange, then reset mid-exchange
    for (int i = 0; i < 5; i++) pulse_spaced();
    ve = 1'b1; step(1);
    check("mid_troca_c1", troca_caixa, 1);
    check("mid_duzias", duzias, 17);
    ve = 1'b0; step(1);
    check("mid_troca_c2", troca_caixa, 1);
    rst = 1'b0; step(1);
    check("mid_rst_troca", troca_caixa, 0);
    check("mid_rst_eb", eb, 0);
    check("mid_rst_rolhas", rolhas, 99);
    check("mid_rst_garrafas", garrafas, 0);
    check("mid_rst_duzias", duzias, 0);
    check("mid_rst_erro", erro, 0);
    rst = 1'b1; step(5);
    check("post_rst_troca", troca_caixa, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
